// File: rtl/ball_physics_engine.sv
`default_nettype none
// ============================================================================
// Module   : ball_physics_engine
// Brief    : Multi-ball fixed-point integrator with saturating velocity,
//            restitution on wall bounce and a sequential per-tick sweep.
// Revision : 1.0
// ============================================================================
module ball_physics_engine #(
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_RADIUS   = 20,
    parameter int N_BALLS       = 4,
    parameter int FRAC_BITS     = 4,
    parameter int VEL_MAX       = 128,
    parameter int REST_SHIFT    = 2,
    parameter int TICK_DIV      = 2**20,
    parameter int X_OUT_W       = 9,
    parameter int Y_OUT_W       = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_reset_position,
    input  logic                         i_pause,
    input  logic [8*N_BALLS-1:0]         i_accel_x,
    input  logic [8*N_BALLS-1:0]         i_accel_y,
    output logic [X_OUT_W*N_BALLS-1:0]   o_ball_x,
    output logic [Y_OUT_W*N_BALLS-1:0]   o_ball_y,
    output logic [N_BALLS-1:0]           o_bounce_x,
    output logic [N_BALLS-1:0]           o_bounce_y,
    output logic                         o_busy,
    output logic                         o_frame_done
);

    localparam int c_PW  = 11 + FRAC_BITS;
    localparam int c_PW1 = c_PW + 1;
    localparam int c_IW  = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
    localparam int c_TW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_TW-1:0]         c_TMAX     = c_TW'(TICK_DIV - 1);
    localparam logic [c_IW-1:0]         c_LAST_IDX = c_IW'(N_BALLS - 1);
    localparam logic signed [12:0]      c_VPOS     = 13'(VEL_MAX);
    localparam logic signed [12:0]      c_VNEG     = -13'(VEL_MAX);
    localparam logic signed [c_PW:0]    c_LO       = c_PW1'(BALL_RADIUS << FRAC_BITS);
    localparam logic signed [c_PW:0]    c_HI_X     = c_PW1'((SCREEN_WIDTH - BALL_RADIUS) << FRAC_BITS);
    localparam logic signed [c_PW:0]    c_HI_Y     = c_PW1'((SCREEN_HEIGHT - BALL_RADIUS) << FRAC_BITS);
    localparam logic signed [c_PW-1:0]  c_START_Y  = c_PW'((SCREEN_HEIGHT / 2) << FRAC_BITS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [c_PW-1:0] p;
        logic [11:0]     v;
        logic            hit;
    } axis_t;

    function automatic logic signed [c_PW-1:0] start_x(input int i);
        return c_PW'((SCREEN_WIDTH * (i + 1) / (N_BALLS + 1)) << FRAC_BITS);
    endfunction

    // One axis of one ball: saturate velocity, then integrate with the new velocity.
    function automatic axis_t axis_step(
        input logic signed [c_PW-1:0] p,
        input logic signed [11:0]     v,
        input logic signed [7:0]      a,
        input logic signed [c_PW:0]   hi
    );
        logic signed [12:0]   v_sum;
        logic signed [11:0]   v1;
        logic signed [11:0]   v_neg;
        logic signed [c_PW:0] p1;
        axis_t                r;
        v_sum = $signed({v[11], v}) + $signed({{5{a[7]}}, a});
        if (v_sum > c_VPOS)      v1 = c_VPOS[11:0];
        else if (v_sum < c_VNEG) v1 = c_VNEG[11:0];
        else                     v1 = v_sum[11:0];
        p1    = $signed({p[c_PW-1], p}) + $signed({{(c_PW - 11){v1[11]}}, v1});
        v_neg = -v1;
        r.p   = p1[c_PW-1:0];
        r.v   = v1;
        r.hit = 1'b0;
        if (p1 < c_LO && v1[11]) begin
            r.p   = c_LO[c_PW-1:0];
            r.v   = v_neg >>> REST_SHIFT;
            r.hit = 1'b1;
        end else if (p1 > hi && !v1[11] && v1 != 12'sd0) begin
            r.p   = hi[c_PW-1:0];
            r.v   = -(v1 >>> REST_SHIFT);
            r.hit = 1'b1;
        end
        return r;
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [c_IW-1:0]         r_idx, w_idx_nxt;
    logic [c_TW-1:0]         r_timer;
    logic                    r_busy;
    logic                    r_frame_done;
    logic [N_BALLS-1:0]      r_bounce_x, r_bounce_y;
    logic signed [c_PW-1:0]  r_px [N_BALLS];
    logic signed [c_PW-1:0]  r_py [N_BALLS];
    logic signed [11:0]      r_vx [N_BALLS];
    logic signed [11:0]      r_vy [N_BALLS];
    logic                    w_tick;
    axis_t                   w_ax, w_ay;

    assign w_tick = (r_timer == c_TMAX) && !i_pause;
    assign w_ax   = axis_step(r_px[r_idx], r_vx[r_idx], i_accel_x[{r_idx, 3'b000} +: 8], c_HI_X);
    assign w_ay   = axis_step(r_py[r_idx], r_vy[r_idx], i_accel_y[{r_idx, 3'b000} +: 8], c_HI_Y);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_UPDATE;
                    w_idx_nxt   = '0;
                end
            end
            S_UPDATE: begin
                if (r_idx == c_LAST_IDX) w_state_nxt = S_DONE;
                else                     w_idx_nxt   = r_idx + c_IW'(1);
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // A position reset aborts any sweep in flight.
        if (i_reset_position) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= (w_state_nxt == S_UPDATE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer      <= '0;
            r_frame_done <= 1'b0;
            r_bounce_x   <= '0;
            r_bounce_y   <= '0;
            for (int i = 0; i < N_BALLS; i++) begin
                r_px[i] <= start_x(i);
                r_py[i] <= c_START_Y;
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
        end else begin
            if (!i_pause) r_timer <= (r_timer == c_TMAX) ? '0 : r_timer + c_TW'(1);
            r_frame_done <= 1'b0;
            r_bounce_x   <= '0;
            r_bounce_y   <= '0;
            if (i_reset_position) begin
                for (int i = 0; i < N_BALLS; i++) begin
                    r_px[i] <= start_x(i);
                    r_py[i] <= c_START_Y;
                    r_vx[i] <= '0;
                    r_vy[i] <= '0;
                end
            end else if (r_state == S_UPDATE) begin
                r_px[r_idx]       <= w_ax.p;
                r_vx[r_idx]       <= w_ax.v;
                r_py[r_idx]       <= w_ay.p;
                r_vy[r_idx]       <= w_ay.v;
                r_bounce_x[r_idx] <= w_ax.hit;
                r_bounce_y[r_idx] <= w_ay.hit;
                r_frame_done      <= (r_idx == c_LAST_IDX);
            end
        end
    end

    generate
        for (genvar i = 0; i < N_BALLS; i++) begin : g_out
            assign o_ball_x[X_OUT_W*i +: X_OUT_W] = r_px[i][FRAC_BITS +: X_OUT_W];
            assign o_ball_y[Y_OUT_W*i +: Y_OUT_W] = r_py[i][FRAC_BITS +: Y_OUT_W];
        end
    endgenerate

    assign o_bounce_x   = r_bounce_x;
    assign o_bounce_y   = r_bounce_y;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire
